// File: rtl/escritor_banco_registros_pkg.sv
// Shared constants and the saturating outstanding-write counter step for the
// register-bank write arbiter.
package escritor_banco_registros_pkg;

  localparam int ANCHO_DATO  = 16;
  localparam int ANCHO_DIR   = 3;
  localparam int NUM_REG     = 8;
  localparam int PROFUNDIDAD = 4;
  localparam int ANCHO_CONT  = 3;

  typedef logic [ANCHO_CONT-1:0] cont_t;

  localparam cont_t CONT_MAX = '1;

  typedef struct packed {
    cont_t valor;
    logic  error;
  } paso_cont_t;

  // A reserve and a retire on the same register cancel out, even at 0 or 7.
  function automatic paso_cont_t paso_contador(cont_t valor, logic inc, logic dec);
    paso_cont_t r;
    r.valor = valor;
    r.error = 1'b0;
    if (inc && !dec) begin
      if (valor == CONT_MAX) r.error = 1'b1;
      else                   r.valor = valor + 1'b1;
    end else if (dec && !inc) begin
      if (valor == '0) r.error = 1'b1;
      else             r.valor = valor - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/escritor_banco_registros_if.sv
// Source handshakes, reservation port and bank write port of the
// register-bank writer, bundled for the top and its bench.
interface escritor_banco_registros_if #(
  parameter int ANCHO_DATO  = escritor_banco_registros_pkg::ANCHO_DATO,
  parameter int PROFUNDIDAD = escritor_banco_registros_pkg::PROFUNDIDAD
);
  import escritor_banco_registros_pkg::*;

  logic                         ValidoAlu;
  logic                         ListoAlu;
  logic [ANCHO_DIR-1:0]         DirAlu;
  logic [ANCHO_DATO-1:0]        DatoAlu;

  logic                         ValidoMem;
  logic                         ListoMem;
  logic [ANCHO_DIR-1:0]         DirMem;
  logic [ANCHO_DATO-1:0]        DatoMem;

  logic                         Reservar;
  logic [ANCHO_DIR-1:0]         DireccionReserva;

  logic                         HabilitarEscritura;
  logic [ANCHO_DIR-1:0]         DireccionEscritura;
  logic [ANCHO_DATO-1:0]        Entrada;

  logic [NUM_REG-1:0]           Pendiente;
  logic [$clog2(PROFUNDIDAD):0] Ocupacion;
  logic                         ErrorReserva;

  modport master (
    output ValidoAlu, DirAlu, DatoAlu,
    output ValidoMem, DirMem, DatoMem,
    output Reservar, DireccionReserva,
    input  ListoAlu, ListoMem,
    input  HabilitarEscritura, DireccionEscritura, Entrada,
    input  Pendiente, Ocupacion, ErrorReserva
  );

  modport slave (
    input  ValidoAlu, DirAlu, DatoAlu,
    input  ValidoMem, DirMem, DatoMem,
    input  Reservar, DireccionReserva,
    output ListoAlu, ListoMem,
    output HabilitarEscritura, DireccionEscritura, Entrada,
    output Pendiente, Ocupacion, ErrorReserva
  );

endinterface

// File: rtl/escritor_banco_registros_fifo_escritura.sv
// Write queue holding {dir, dato} entries between the result sources and
// the register bank. Head is shown as zero while empty.
module fifo_escritura #(
  parameter int ANCHO       = 19,
  parameter int PROFUNDIDAD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ANCHO-1:0] dato_push,
  input  logic             pop,
  output logic [ANCHO-1:0] dato_cabeza,
  output logic             lleno,
  output logic             vacio,
  output logic [$clog2(PROFUNDIDAD):0] cuenta
);

  localparam int ANCHO_PTR = $clog2(PROFUNDIDAD);

  logic [ANCHO-1:0]     mem [PROFUNDIDAD];
  logic [ANCHO_PTR-1:0] ptr_lect;
  logic [ANCHO_PTR-1:0] ptr_escr;
  logic [ANCHO_PTR:0]   cuenta_q;
  logic                 hace_push;
  logic                 hace_pop;

  assign lleno     = (cuenta_q == (ANCHO_PTR+1)'(PROFUNDIDAD));
  assign vacio     = (cuenta_q == '0);
  assign hace_push = push & ~lleno;
  assign hace_pop  = pop & ~vacio;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_lect <= '0;
      ptr_escr <= '0;
      cuenta_q <= '0;
    end else begin
      if (hace_push) ptr_escr <= ptr_escr + 1'b1;
      if (hace_pop)  ptr_lect <= ptr_lect + 1'b1;
      if (hace_push && !hace_pop)      cuenta_q <= cuenta_q + 1'b1;
      else if (hace_pop && !hace_push) cuenta_q <= cuenta_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hace_push) mem[ptr_escr] <= dato_push;
  end

  assign dato_cabeza = vacio ? '0 : mem[ptr_lect];
  assign cuenta      = cuenta_q;

endmodule

// File: rtl/escritor_banco_registros.sv
// Arbitrates ALU and memory results into a write queue that drains into the
// register bank one entry per cycle, and tracks reserved-but-unwritten registers.
module escritor_banco_registros #(
  parameter int ANCHO_DATO  = escritor_banco_registros_pkg::ANCHO_DATO,
  parameter int PROFUNDIDAD = escritor_banco_registros_pkg::PROFUNDIDAD
) (
  input logic                       Reloj,
  input logic                       Reiniciar,
  escritor_banco_registros_if.slave bus
);
  import escritor_banco_registros_pkg::*;

  localparam int ANCHO_ENTRADA = ANCHO_DIR + ANCHO_DATO;
  localparam int ANCHO_OCUP    = $clog2(PROFUNDIDAD) + 1;

  logic                     lleno;
  logic                     vacio;
  logic                     push;
  logic                     pop;
  logic                     push_mem;
  logic                     push_alu;
  logic [ANCHO_ENTRADA-1:0] entrada_push;
  logic [ANCHO_ENTRADA-1:0] cabeza;
  logic [ANCHO_OCUP-1:0]    ocupacion;

  cont_t                    contador [NUM_REG];
  paso_cont_t               paso_v   [NUM_REG];
  logic [NUM_REG-1:0]       error_paso;
  logic [NUM_REG-1:0]       pendiente;
  logic                     error_reserva;

  // Memory results have fixed priority over ALU results.
  assign bus.ListoMem = ~lleno;
  assign bus.ListoAlu = ~lleno & ~bus.ValidoMem;
  assign push_mem     = bus.ValidoMem & ~lleno;
  assign push_alu     = bus.ValidoAlu & bus.ListoAlu;
  assign push         = push_mem | push_alu;
  assign entrada_push = push_mem ? {bus.DirMem, bus.DatoMem}
                                 : {bus.DirAlu, bus.DatoAlu};
  assign pop          = ~vacio;

  fifo_escritura #(
    .ANCHO       (ANCHO_ENTRADA),
    .PROFUNDIDAD (PROFUNDIDAD)
  ) u_fifo (
    .clk         (Reloj),
    .rst         (Reiniciar),
    .push        (push),
    .dato_push   (entrada_push),
    .pop         (pop),
    .dato_cabeza (cabeza),
    .lleno       (lleno),
    .vacio       (vacio),
    .cuenta      (ocupacion)
  );

  assign bus.HabilitarEscritura = ~vacio;
  assign bus.DireccionEscritura = cabeza[ANCHO_ENTRADA-1 -: ANCHO_DIR];
  assign bus.Entrada            = cabeza[ANCHO_DATO-1:0];
  assign bus.Ocupacion          = ocupacion;
  assign bus.Pendiente          = pendiente;
  assign bus.ErrorReserva       = error_reserva;

  always_comb begin
    for (int i = 0; i < NUM_REG; i++) begin
      paso_v[i]     = paso_contador(contador[i],
                        bus.Reservar && (bus.DireccionReserva == ANCHO_DIR'(i)),
                        pop && (bus.DireccionEscritura == ANCHO_DIR'(i)));
      error_paso[i] = paso_v[i].error;
      pendiente[i]  = (contador[i] != '0);
    end
  end

  always_ff @(posedge Reloj or posedge Reiniciar) begin
    if (Reiniciar) begin
      for (int i = 0; i < NUM_REG; i++) contador[i] <= '0;
      error_reserva <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REG; i++) contador[i] <= paso_v[i].valor;
      error_reserva <= error_reserva | (|error_paso);
    end
  end

endmodule

// File: tb/tb_escritor_banco_registros.sv
// Bench for escritor_banco_registros: queue/scoreboard model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_escritor_banco_registros;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  escritor_banco_registros_if bus ();
  escritor_banco_registros dut (.Reloj(clk), .Reiniciar(rst), .bus(bus));

  typedef struct {
    logic [2:0]  dir;
    logic [15:0] dato;
  } ent_t;

  ent_t m_cola[$];
  int   m_cont [8];
  bit   m_err;
  bit   gate;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes plus per-register counts.
  always @(posedge clk or posedge rst) begin : modelo
    int   net;
    bit   hay_pop;
    bit   lleno;
    ent_t cab;
    if (rst) begin
      m_cola.delete();
      foreach (m_cont[i]) m_cont[i] = 0;
      m_err = 1'b0;
    end else begin
      lleno   = (m_cola.size() == 4);
      hay_pop = (m_cola.size() != 0) && !gate;
      if (hay_pop) cab = m_cola[0];
      for (int i = 0; i < 8; i++) begin
        net = ((bus.Reservar && bus.DireccionReserva == 3'(i)) ? 1 : 0)
            - ((hay_pop && cab.dir == 3'(i)) ? 1 : 0);
        if (net > 0) begin
          if (m_cont[i] == 7) m_err = 1'b1; else m_cont[i]++;
        end else if (net < 0) begin
          if (m_cont[i] == 0) m_err = 1'b1; else m_cont[i]--;
        end
      end
      if (hay_pop) void'(m_cola.pop_front());
      if (!lleno) begin
        if (bus.ValidoMem)      m_cola.push_back('{bus.DirMem, bus.DatoMem});
        else if (bus.ValidoAlu) m_cola.push_back('{bus.DirAlu, bus.DatoAlu});
      end
    end
  end

  always @(negedge clk) begin : comparar
    int          n;
    logic [2:0]  e_dir;
    logic [15:0] e_dat;
    logic [7:0]  e_pend;
    n     = m_cola.size();
    e_dir = (n != 0) ? m_cola[0].dir  : 3'd0;
    e_dat = (n != 0) ? m_cola[0].dato : 16'd0;
    for (int i = 0; i < 8; i++) e_pend[i] = (m_cont[i] != 0);
    chk("hab",       32'(bus.HabilitarEscritura), 32'(n != 0));
    chk("dir",       32'(bus.DireccionEscritura), 32'(e_dir));
    chk("entrada",   32'(bus.Entrada),            32'(e_dat));
    chk("ocupacion", 32'(bus.Ocupacion),          32'(n));
    chk("listo_mem", 32'(bus.ListoMem),           32'(n < 4));
    chk("listo_alu", 32'(bus.ListoAlu),           32'((n < 4) && !bus.ValidoMem));
    chk("pendiente", 32'(bus.Pendiente),          32'(e_pend));
    chk("error",     32'(bus.ErrorReserva),       32'(m_err));
  end

  task automatic paso();
    @(posedge clk);
    #2;
  endtask

  task automatic limpiar();
    bus.ValidoAlu = 1'b0; bus.DirAlu = '0; bus.DatoAlu = '0;
    bus.ValidoMem = 1'b0; bus.DirMem = '0; bus.DatoMem = '0;
    bus.Reservar  = 1'b0; bus.DireccionReserva = '0;
  endtask

  // Holding the bank pop off is the only way to let the queue fill.
  task automatic set_gate(input bit g);
    gate = g;
    if (g) force dut.pop = 1'b0;
    else   release dut.pop;
  endtask

  task automatic reiniciar();
    limpiar();
    set_gate(1'b0);
    rst = 1'b1;
    paso();
    rst = 1'b0;
  endtask

  task automatic alu(input logic [2:0] d, input logic [15:0] v);
    bus.ValidoAlu = 1'b1; bus.DirAlu = d; bus.DatoAlu = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end on its own");
    $fatal(1, "watchdog");
  end

  initial begin
    limpiar();
    gate = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_hab",  32'(bus.HabilitarEscritura), 32'd0);
    chk("rst_ocup", 32'(bus.Ocupacion),          32'd0);
    chk("rst_listo", 32'({bus.ListoAlu, bus.ListoMem}), 32'h3);
    chk("rst_pend", 32'(bus.Pendiente),          32'd0);
    rst = 1'b0;

    // Single ALU write, one-cycle latency to the bank.
    bus.Reservar = 1'b1; bus.DireccionReserva = 3'd3;
    alu(3'd3, 16'hBEEF);
    paso(); limpiar();
    chk("t1_hab",  32'(bus.HabilitarEscritura), 32'd1);
    chk("t1_dir",  32'(bus.DireccionEscritura), 32'd3);
    chk("t1_ent",  32'(bus.Entrada),            32'hBEEF);
    chk("t1_pend", 32'(bus.Pendiente),          32'h08);
    paso();
    chk("t1_vacia", 32'({bus.HabilitarEscritura, bus.Ocupacion}), 32'd0);
    chk("t1_err",   32'(bus.ErrorReserva), 32'd0);

    // Memory beats ALU when both are valid.
    bus.Reservar = 1'b1; bus.DireccionReserva = 3'd1; paso();
    bus.DireccionReserva = 3'd2; paso();
    bus.Reservar = 1'b0;
    alu(3'd1, 16'h1111);
    bus.ValidoMem = 1'b1; bus.DirMem = 3'd2; bus.DatoMem = 16'h2222;
    #1;
    chk("t2_listo_alu", 32'(bus.ListoAlu), 32'd0);
    chk("t2_listo_mem", 32'(bus.ListoMem), 32'd1);
    paso(); bus.ValidoMem = 1'b0;
    chk("t2_primero", 32'({bus.DireccionEscritura, bus.Entrada}), 32'h2_2222);
    paso(); bus.ValidoAlu = 1'b0;
    chk("t2_segundo", 32'({bus.DireccionEscritura, bus.Entrada}), 32'h1_1111);
    paso();
    chk("t2_fin", 32'({bus.ErrorReserva, bus.Ocupacion, bus.Pendiente}), 32'd0);

    // Fill the queue with the bank stalled; the fifth push must be refused.
    set_gate(1'b1);
    for (int k = 0; k < 4; k++) begin
      alu(3'(k + 4), 16'(16'hA000 + k));
      paso();
    end
    alu(3'd1, 16'h5555);
    bus.ValidoMem = 1'b1; bus.DirMem = 3'd2; bus.DatoMem = 16'h6666;
    #1;
    chk("t3_ocup",  32'(bus.Ocupacion), 32'd4);
    chk("t3_listo", 32'({bus.ListoAlu, bus.ListoMem}), 32'd0);
    paso(); limpiar();
    chk("t3_rechazo", 32'({bus.Ocupacion, bus.Entrada}), 32'h4_A000);
    set_gate(1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t3_orden", 32'({bus.DireccionEscritura, bus.Entrada}),
          32'({3'(k + 4), 16'(16'hA000 + k)}));
      paso();
    end
    chk("t3_vacia", 32'(bus.Ocupacion), 32'd0);
    chk("t3_err",   32'(bus.ErrorReserva), 32'd1);

    // Two reservations on register 5 retired by two writes.
    reiniciar();
    bus.Reservar = 1'b1; bus.DireccionReserva = 3'd5;
    paso(); paso();
    bus.Reservar = 1'b0;
    chk("t4_pend_a", 32'(bus.Pendiente), 32'h20);
    alu(3'd5, 16'h0A0A); paso();
    alu(3'd5, 16'h0B0B); paso();
    bus.ValidoAlu = 1'b0;
    chk("t4_pend_b", 32'({bus.Pendiente, bus.Entrada}), 32'h20_0B0B);
    paso();
    chk("t4_pend_c", 32'({bus.ErrorReserva, bus.Pendiente}), 32'd0);

    // Counter saturation and underflow both set the sticky error.
    reiniciar();
    bus.Reservar = 1'b1; bus.DireccionReserva = 3'd0;
    repeat (7) paso();
    chk("t5_siete", 32'({bus.ErrorReserva, bus.Pendiente}), 32'h001);
    paso();
    bus.Reservar = 1'b0;
    chk("t5_sat", 32'({bus.ErrorReserva, bus.Pendiente}), 32'h101);
    reiniciar();
    alu(3'd6, 16'h6666); paso();
    bus.ValidoAlu = 1'b0;
    chk("t5_antes", 32'(bus.ErrorReserva), 32'd0);
    paso();
    chk("t5_under", 32'(bus.ErrorReserva), 32'd1);

    // Reset with three entries queued discards them.
    reiniciar();
    bus.Reservar = 1'b1; bus.DireccionReserva = 3'd2; paso();
    bus.Reservar = 1'b0;
    set_gate(1'b1);
    for (int k = 0; k < 3; k++) begin
      alu(3'd2, 16'(16'hC000 + k));
      paso();
    end
    limpiar();
    chk("t6_antes", 32'({bus.Ocupacion, bus.Pendiente}), 32'h3_04);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_salidas", 32'({bus.HabilitarEscritura, bus.DireccionEscritura, bus.Entrada}), 32'd0);
    chk("t6_estado",  32'({bus.Ocupacion, bus.Pendiente, bus.ErrorReserva}), 32'd0);
    chk("t6_listo",   32'({bus.ListoAlu, bus.ListoMem}), 32'h3);
    set_gate(1'b0);
    paso();
    rst = 1'b0;
    repeat (5) begin
      paso();
      chk("t6_sin_escritura", 32'(bus.HabilitarEscritura), 32'd0);
    end

    // Random traffic with stalls and occasional resets.
    reiniciar();
    for (int c = 0; c < 2000; c++) begin
      if (c % 300 == 299) reiniciar();
      bus.ValidoAlu        = ($urandom_range(0, 99) < 60);
      bus.DirAlu           = 3'($urandom_range(0, 7));
      bus.DatoAlu          = 16'($urandom);
      bus.ValidoMem        = ($urandom_range(0, 99) < 35);
      bus.DirMem           = 3'($urandom_range(0, 7));
      bus.DatoMem          = 16'($urandom);
      bus.Reservar         = ($urandom_range(0, 99) < 40);
      bus.DireccionReserva = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) set_gate(!gate);
      paso();
    end

    set_gate(1'b0);
    limpiar();
    paso();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
